// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: default bus widths, well-known
// master indices and a width helper used for index and counter sizing.
package bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Fixed master slots: the CPU always sits on port 0, first DMA on port 1.
    localparam int MASTER_CPU = 0;
    localparam int MASTER_DMA = 1;

    // Width of the owner output port.
    localparam int OWNER_W = 2;

    // Smallest width w (at least 1) such that 2**w >= n.
    function automatic int idx_width(input int n);
        int w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first eligible requester
// scanning upward from ptr with wrap-around, as a one-hot grant plus index.
module rr_priority_picker
    import bus_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     exclude,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     eligible;
    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    // A master is eligible when it requests and is not masked out.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign eligible[gi] = req[gi] & ~exclude[gi];
        end
    endgenerate

    // Rotate so that bit k corresponds to master (ptr + k) mod N.
    assign doubled = {eligible, eligible};
    assign rotated = N'(doubled >> ptr);

    // Find the lowest set bit of the rotated vector (closest to ptr).
    always_comb begin
        any    = 1'b0;
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                any    = 1'b1;
                offset = IDX_W'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute master index.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(N)) begin
            idx = IDX_W'(sum - (IDX_W + 1)'(N));
        end else begin
            idx = IDX_W'(sum);
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = any && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_arbiter.sv
// Shared data bus arbiter: zero-latency grant, ownership held while the
// request stays high, round-robin rotation on release and a hold limit
// that forces hand-over when another master is waiting.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_HOLD    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    output logic [NUM_MASTERS-1:0]        m_grant,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [NUM_MASTERS-1:0]        m_rd,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wr_data,
    output logic                          s_wr,
    output logic                          s_rd,
    output logic                          bus_busy,
    output logic [OWNER_W-1:0]            owner
);

    localparam int IDX_W    = idx_width(NUM_MASTERS);
    localparam int HOLD_W   = idx_width(MAX_HOLD + 1);
    // With an unlimited hold the counter value is irrelevant; park it at 1.
    localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;

    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
            $error("bus_arbiter: NUM_MASTERS must be in 2..4");
        end
    endgenerate

    logic [IDX_W-1:0]  rr_ptr_reg,   rr_ptr_next;
    logic              locked_reg,   locked_next;
    logic [IDX_W-1:0]  lock_idx_reg, lock_idx_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic [NUM_MASTERS-1:0] lock_onehot;
    logic [NUM_MASTERS-1:0] exclude;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   others_req;
    logic                   hold_full;
    logic                   expired;
    logic                   keep;
    logic [NUM_MASTERS-1:0] grant_raw;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [IDX_W-1:0]       owner_idx;

    logic [ADDR_W-1:0] addr_term [NUM_MASTERS];
    logic [DATA_W-1:0] data_term [NUM_MASTERS];

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_lock_onehot
            assign lock_onehot[gi] = (lock_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Hold expiry and the decision whether the current owner keeps the bus.
    always_comb begin
        others_req = |(m_req & ~lock_onehot);
        hold_full  = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_W'(HOLD_SAT));
        expired    = locked_reg && hold_full && others_req;
        keep       = locked_reg && (|(m_req & lock_onehot)) && !expired;
        exclude    = expired ? lock_onehot : '0;
    end

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (m_req),
        .ptr     (rr_ptr_reg),
        .exclude (exclude),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // Final grant; reset suppresses it combinationally in the same cycle.
    always_comb begin
        grant_raw = keep ? lock_onehot : pick_grant;
        grant_idx = keep ? lock_idx_reg : pick_idx;
        grant_any = keep | pick_any;
        m_grant   = rst ? '0 : grant_raw;
        bus_busy  = |m_grant;
        owner_idx = bus_busy ? grant_idx : '0;
        owner     = OWNER_W'(owner_idx);
        s_wr      = m_wr[owner_idx] & bus_busy;
        s_rd      = m_rd[owner_idx] & bus_busy;
    end

    // AND-OR mux terms: a non-granted master contributes all zeros.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mux_terms
            assign addr_term[gi] = m_addr[gi*ADDR_W +: ADDR_W] & {ADDR_W{m_grant[gi]}};
            assign data_term[gi] = m_wr_data[gi*DATA_W +: DATA_W] & {DATA_W{m_grant[gi]}};
        end
    endgenerate

    // OR-combine the masked address and write data onto the slave side.
    always_comb begin
        s_addr    = '0;
        s_wr_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_addr    = s_addr | addr_term[i];
            s_wr_data = s_wr_data | data_term[i];
        end
    end

    // Ownership, hold counter and priority pointer updates.
    always_comb begin
        rr_ptr_next   = rr_ptr_reg;
        locked_next   = locked_reg;
        lock_idx_next = lock_idx_reg;
        hold_cnt_next = hold_cnt_reg;
        if (grant_any) begin
            locked_next   = 1'b1;
            lock_idx_next = grant_idx;
            if (locked_reg && (grant_idx == lock_idx_reg)) begin
                if (hold_cnt_reg != HOLD_W'(HOLD_SAT)) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end else begin
                hold_cnt_next = HOLD_W'(1);
            end
        end else begin
            locked_next   = 1'b0;
            hold_cnt_next = '0;
        end
        // The previous owner lost the bus: the master after it gets top priority.
        if (locked_reg && !(grant_any && (grant_idx == lock_idx_reg))) begin
            if (lock_idx_reg == IDX_W'(NUM_MASTERS - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = lock_idx_reg + IDX_W'(1);
            end
        end
    end

    // State register with synchronous reset; CPU has top priority after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg   <= IDX_W'(MASTER_CPU);
            locked_reg   <= 1'b0;
            lock_idx_reg <= '0;
            hold_cnt_reg <= '0;
        end else begin
            rr_ptr_reg   <= rr_ptr_next;
            locked_reg   <= locked_next;
            lock_idx_reg <= lock_idx_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the stimulus process computes the
// expected slave-side response from a behavioural ownership model and queues
// it; a negedge monitor pops and compares, and also checks grant invariants
// and the starvation bound.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int MH = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int STARVE_MAX = (N - 1) * MH + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_grant;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wr_data;
    logic [N-1:0]      m_wr;
    logic [N-1:0]      m_rd;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wr_data;
    logic              s_wr;
    logic              s_rd;
    logic              bus_busy;
    logic [1:0]        owner;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_HOLD    (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_grant   (m_grant),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_wr      (m_wr),
        .m_rd      (m_rd),
        .s_addr    (s_addr),
        .s_wr_data (s_wr_data),
        .s_wr      (s_wr),
        .s_rd      (s_rd),
        .bus_busy  (bus_busy),
        .owner     (owner)
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic [1:0]    owner;
        logic          busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wr;
        logic          rd;
        bit            chk;
        logic [N-1:0]  cg;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model state: current owner (-1 = none), how many cycles it
    // has held the bus in a row, and who gets first look at the next free bus.
    int mdl_own = -1;
    int mdl_run = 0;
    int mdl_ptr = 0;

    task automatic step(input logic r, input logic [N-1:0] req,
                        input logic [N-1:0] wr, input logic [N-1:0] rd,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit chk, input logic [N-1:0] cg);
        exp_t          e;
        int            gi;
        bit            others;
        bit            exp_flag;
        int            c;
        logic [AW-1:0] av [N];
        logic [DW-1:0] dv [N];
        @(posedge clk);
        #1;
        rst       = r;
        m_req     = req;
        m_wr      = wr;
        m_rd      = rd;
        m_addr    = {a1, a0};
        m_wr_data = {d1, d0};
        av[0] = a0; av[1] = a1;
        dv[0] = d0; dv[1] = d1;
        gi = -1;
        if (r) begin
            mdl_own = -1;
            mdl_run = 0;
            mdl_ptr = MASTER_CPU;
        end else begin
            others = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (req[j] && j != mdl_own) others = 1'b1;
            end
            exp_flag = (MH != 0) && (mdl_own >= 0) && (mdl_run >= MH) && others;
            if (mdl_own >= 0 && req[mdl_own] && !exp_flag) begin
                gi = mdl_own;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (mdl_ptr + k) % N;
                    if (gi < 0 && req[c] && !(exp_flag && c == mdl_own)) gi = c;
                end
            end
            if (mdl_own >= 0 && gi != mdl_own) mdl_ptr = (mdl_own + 1) % N;
            if (gi >= 0) begin
                mdl_run = (gi == mdl_own) ? mdl_run + 1 : 1;
                mdl_own = gi;
            end else begin
                mdl_own = -1;
                mdl_run = 0;
            end
        end
        e.grant = '0;
        e.owner = 2'd0;
        e.busy  = 1'b0;
        e.addr  = '0;
        e.data  = '0;
        e.wr    = 1'b0;
        e.rd    = 1'b0;
        if (gi >= 0) begin
            e.grant[gi] = 1'b1;
            e.owner     = 2'(gi);
            e.busy      = 1'b1;
            e.addr      = av[gi];
            e.data      = dv[gi];
            e.wr        = wr[gi];
            e.rd        = rd[gi];
        end
        e.chk = chk;
        e.cg  = cg;
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT against queued expectations at the falling edge.
    initial begin
        int   wait_cnt [N];
        int   txn;
        exp_t e;
        txn = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                txn++;
                tests++;
                if (m_grant !== e.grant || owner !== e.owner || bus_busy !== e.busy ||
                    s_addr !== e.addr || s_wr_data !== e.data || s_wr !== e.wr || s_rd !== e.rd) begin
                    fails++;
                    $display("FAIL txn %0d response: got grant=%b owner=%0d busy=%b addr=%h data=%h wr=%b rd=%b, want grant=%b owner=%0d busy=%b addr=%h data=%h wr=%b rd=%b",
                             txn, m_grant, owner, bus_busy, s_addr, s_wr_data, s_wr, s_rd,
                             e.grant, e.owner, e.busy, e.addr, e.data, e.wr, e.rd);
                end else begin
                    $display("[TB] txn %0d rst=%b req=%b grant=%b owner=%0d addr=%h data=%h wr=%b rd=%b",
                             txn, rst, m_req, m_grant, owner, s_addr, s_wr_data, s_wr, s_rd);
                end
                if (e.chk) begin
                    tests++;
                    if (m_grant !== e.cg) begin
                        fails++;
                        $display("FAIL txn %0d directed_grant: got %b, want %b", txn, m_grant, e.cg);
                    end
                end
                tests++;
                if (!$onehot0(m_grant) || ((m_grant & ~m_req) != '0)) begin
                    fails++;
                    $display("FAIL txn %0d grant_invariant: grant=%b req=%b", txn, m_grant, m_req);
                end
                for (int i = 0; i < N; i++) begin
                    if (!rst && m_req[i] && !m_grant[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    tests++;
                    if (wait_cnt[i] > STARVE_MAX) begin
                        fails++;
                        $display("FAIL txn %0d starvation m%0d: waited %0d, limit %0d",
                                 txn, i, wait_cnt[i], STARVE_MAX);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [N-1:0] rq;
        rst       = 1'b1;
        m_req     = '0;
        m_wr      = '0;
        m_rd      = '0;
        m_addr    = '0;
        m_wr_data = '0;

        // Reset state.
        step(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'b00);
        step(1'b1, 2'b11, 2'b11, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2'b00);

        // Simultaneous request after reset: CPU wins; then hand-over and rotation.
        step(1'b0, 2'b11, 2'b00, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2'b01);
        step(1'b0, 2'b10, 2'b00, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2'b10);
        step(1'b0, 2'b10, 2'b00, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2'b10);
        step(1'b0, 2'b00, 2'b00, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2'b00);
        step(1'b0, 2'b11, 2'b00, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2'b01);
        step(1'b0, 2'b00, 2'b00, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2'b00);

        // Hold limit: master 1 holds 4 cycles while master 0 waits, then hands over.
        step(1'b0, 2'b10, 2'b00, 2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 2'b10);
        for (int k = 0; k < 3; k++)
            step(1'b0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 2'b10);
        step(1'b0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 2'b01);
        step(1'b0, 2'b00, 2'b00, 2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 2'b00);

        // Master 1 alone never expires.
        for (int k = 0; k < 8; k++)
            step(1'b0, 2'b10, 2'b00, 2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 2'b10);
        step(1'b0, 2'b00, 2'b00, 2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 2'b00);

        // CPU write routed to the slave; master 1 strobes must not leak.
        step(1'b0, 2'b01, 2'b11, 2'b10, 8'h80, 8'hC3, 8'h5A, 8'hA5, 1'b1, 2'b01);
        step(1'b0, 2'b00, 2'b11, 2'b11, 8'h80, 8'hC3, 8'h5A, 8'hA5, 1'b1, 2'b00);

        // Reset while master 1 owns the bus drops the grant in that cycle.
        step(1'b0, 2'b10, 2'b10, 2'b10, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 2'b10);
        step(1'b1, 2'b10, 2'b10, 2'b10, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 2'b00);
        step(1'b0, 2'b11, 2'b11, 2'b11, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 2'b01);

        // Randomized traffic with sticky requests and occasional resets.
        rq = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) rq[b] = ~rq[b];
            end
            step(($urandom_range(499) == 0), rq, 2'($urandom), 2'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2'b00);
        end

        // Let the monitor drain the scoreboard, bounded.
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
